// File: rtl/pong_pkg.sv
// Shared Pong geometry, colours, default paddle positions and the plotter state type.
package pong_pkg;

  localparam int unsigned SCREEN_W = 256;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned PADDLE_W = 4;
  localparam int unsigned PADDLE_H = 20;

  localparam logic [2:0] FG_COLOUR = 3'b111;
  localparam logic [2:0] BG_COLOUR = 3'b000;

  localparam logic [7:0] DEF_LX = 8'd0;
  localparam logic [7:0] DEF_LY = 8'(SCREEN_H / 2 - 10);
  localparam logic [7:0] DEF_RX = 8'(SCREEN_W - PADDLE_W);
  localparam logic [7:0] DEF_RY = 8'(SCREEN_H / 2 - 10);

  localparam logic [8:0] X_MAX = 9'(SCREEN_W - PADDLE_W);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_H - PADDLE_H);

  localparam int unsigned COL_W = $clog2(PADDLE_W);
  localparam int unsigned ROW_W = $clog2(PADDLE_H);

  typedef enum logic [2:0] {
    IDLE,
    ERASE_L,
    ERASE_R,
    DRAW_L,
    DRAW_R,
    DONE
  } plot_state_e;

  // Widened compare so coordinates near 255 cannot wrap past the limit.
  function automatic logic [7:0] clamp_coord(input logic [7:0] v, input logic [8:0] lim);
    logic [8:0] w;
    w = {1'b0, v};
    return (w > lim) ? lim[7:0] : v;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major col/row counter that walks one paddle-sized rectangle, one pixel per enabled cycle.
module rect_scanner
  import pong_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PADDLE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PADDLE_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (enable_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/paddle_plotter.sv
// Erases both paddles at their old positions, then draws them at the newly latched ones,
// emitting one registered VGA pixel write per clock.
module paddle_plotter
  import pong_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] lx,
  input  logic [7:0] ly,
  input  logic [7:0] rx,
  input  logic [7:0] ry,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  plot_state_e state_q, state_d;

  logic [7:0] old_lx_q, old_ly_q, old_rx_q, old_ry_q;
  logic [7:0] new_lx_q, new_ly_q, new_rx_q, new_ry_q;

  logic [7:0] vga_x_q, vga_y_q;
  logic [2:0] colour_q;
  logic       plot_q, busy_q, done_q;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last;
  logic             scanning;
  logic             clear;
  logic [7:0]       base_x, base_y;
  logic [2:0]       colour_d;
  logic [7:0]       px, py;

  rect_scanner u_scan (
    .clk_i    (CLOCK_50),
    .rst_ni   (resetn),
    .clear_i  (clear),
    .enable_i (scanning),
    .col_o    (col),
    .row_o    (row),
    .last_o   (last)
  );

  always_comb begin
    state_d  = state_q;
    scanning = 1'b0;
    base_x   = '0;
    base_y   = '0;
    colour_d = BG_COLOUR;
    unique case (state_q)
      IDLE: if (start) state_d = ERASE_L;
      ERASE_L: begin
        scanning = 1'b1;
        base_x   = old_lx_q;
        base_y   = old_ly_q;
        if (last) state_d = ERASE_R;
      end
      ERASE_R: begin
        scanning = 1'b1;
        base_x   = old_rx_q;
        base_y   = old_ry_q;
        if (last) state_d = DRAW_L;
      end
      DRAW_L: begin
        scanning = 1'b1;
        base_x   = new_lx_q;
        base_y   = new_ly_q;
        colour_d = FG_COLOUR;
        if (last) state_d = DRAW_R;
      end
      DRAW_R: begin
        scanning = 1'b1;
        base_x   = new_rx_q;
        base_y   = new_ry_q;
        colour_d = FG_COLOUR;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    clear = (state_d != state_q);
    // Clamped bases guarantee these sums never exceed 255.
    px = base_x + 8'(col);
    py = base_y + 8'(row);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= IDLE;
      vga_x_q  <= '0;
      vga_y_q  <= '0;
      colour_q <= BG_COLOUR;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      old_lx_q <= DEF_LX;
      old_ly_q <= DEF_LY;
      old_rx_q <= DEF_RX;
      old_ry_q <= DEF_RY;
      new_lx_q <= DEF_LX;
      new_ly_q <= DEF_LY;
      new_rx_q <= DEF_RX;
      new_ry_q <= DEF_RY;
    end else begin
      state_q <= state_d;
      plot_q  <= scanning;
      busy_q  <= (state_q != IDLE);
      done_q  <= (state_q == DONE);
      if (scanning) begin
        vga_x_q  <= px;
        vga_y_q  <= py;
        colour_q <= colour_d;
      end
      if (state_q == IDLE && start) begin
        new_lx_q <= clamp_coord(lx, X_MAX);
        new_ly_q <= clamp_coord(ly, Y_MAX);
        new_rx_q <= clamp_coord(rx, X_MAX);
        new_ry_q <= clamp_coord(ry, Y_MAX);
      end
      if (state_q == DONE) begin
        old_lx_q <= new_lx_q;
        old_ly_q <= new_ly_q;
        old_rx_q <= new_rx_q;
        old_ry_q <= new_ry_q;
      end
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_paddle_plotter.sv
// Scoreboard bench for paddle_plotter: stimulus queues expected pixels, a negedge monitor checks them.
module tb_paddle_plotter;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic [7:0] lx = 8'd0, ly = 8'd110, rx = 8'd252, ry = 8'd110;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   plot_total = 0;
  logic prev_plot = 1'b0;

  // Bench model of the previously drawn positions.
  logic [7:0] m_lx = 8'd0, m_ly = 8'd110, m_rx = 8'd252, m_ry = 8'd110;

  paddle_plotter dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .lx         (lx),
    .ly         (ly),
    .rx         (rx),
    .ry         (ry),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    pix_t e;
    if (plot === 1'b1) begin
      plot_total++;
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pixel_xyc", {5'b0, vga_x, vga_y, vga_colour}, {5'b0, e.x, e.y, e.c});
      end
    end
    if (done === 1'b1) check("done_after_last_plot", {30'b0, prev_plot, plot}, 32'd2);
    prev_plot = plot;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [7:0] clampv(input logic [7:0] v, input int lim);
    return (int'(v) > lim) ? 8'(lim) : v;
  endfunction

  task automatic push_rect(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    pix_t p;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) begin
        p.x = x + 8'(k);
        p.y = y + 8'(r);
        p.c = c;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic push_pass(input logic [7:0] nlx, input logic [7:0] nly,
                           input logic [7:0] nrx, input logic [7:0] nry);
    logic [7:0] cl_lx, cl_ly, cl_rx, cl_ry;
    cl_lx = clampv(nlx, 252);
    cl_ly = clampv(nly, 220);
    cl_rx = clampv(nrx, 252);
    cl_ry = clampv(nry, 220);
    push_rect(m_lx, m_ly, 3'b000);
    push_rect(m_rx, m_ry, 3'b000);
    push_rect(cl_lx, cl_ly, 3'b111);
    push_rect(cl_rx, cl_ry, 3'b111);
    m_lx = cl_lx;
    m_ly = cl_ly;
    m_rx = cl_rx;
    m_ry = cl_ry;
  endtask

  task automatic run_pass(input logic [7:0] nlx, input logic [7:0] nly,
                          input logic [7:0] nrx, input logic [7:0] nry, input bit glitch);
    int  c;
    int  pt;
    bit  seen;
    push_pass(nlx, nly, nrx, nry);
    lx = nlx; ly = nly; rx = nrx; ry = nry;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("quiet_after_start_edge", {30'b0, busy, plot}, 32'd0);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 400) begin
      tick();
      c++;
      if (c == 1) check("first_plot_latency", {30'b0, busy, plot}, 32'd3);
      if (glitch && (c == 5 || c == 200)) begin
        start = 1'b1;
        lx = nlx + 8'd40; ly = 8'd5; rx = 8'd100; ry = 8'd7;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_cycle", 32'(c), 32'd321);
    check("busy_in_done", {31'b0, busy}, 32'd1);
    tick();
    check("idle_after_done", {29'b0, busy, done, plot}, 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (glitch) begin
      pt = plot_total;
      repeat (40) tick();
      check("no_queued_pass", 32'(plot_total - pt), 32'd0);
    end
  endtask

  initial begin
    int pt;
    int dones, d1, p2;

    // Reset then idle
    resetn = 1'b0;
    start  = 1'b0;
    repeat (2) tick();
    check("reset_outputs", {10'b0, vga_x, vga_y, vga_colour, plot, busy, done}, 32'd0);
    resetn = 1'b1;
    pt = plot_total;
    repeat (50) tick();
    check("idle_no_plot", 32'(plot_total - pt), 32'd0);
    check("idle_outputs", {10'b0, vga_x, vga_y, vga_colour, plot, busy, done}, 32'd0);

    // Default pass, then a clamped move
    run_pass(8'd0, 8'd110, 8'd252, 8'd110, 1'b0);
    run_pass(8'd0, 8'd250, 8'd255, 8'd110, 1'b0);

    // Start pulses while busy are ignored
    run_pass(8'd8, 8'd50, 8'd200, 8'd100, 1'b1);

    // Reset mid-pass at plot 100
    push_pass(8'd20, 8'd30, 8'd230, 8'd60);
    lx = 8'd20; ly = 8'd30; rx = 8'd230; ry = 8'd60;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    check("plot_at_100", {31'b0, plot}, 32'd1);
    resetn = 1'b0;
    tick();
    check("reset_mid_pass", {30'b0, busy, plot}, 32'd0);
    exp_q.delete();
    m_lx = 8'd0; m_ly = 8'd110; m_rx = 8'd252; m_ry = 8'd110;
    tick();
    resetn = 1'b1;
    tick();
    run_pass(8'd40, 8'd70, 8'd200, 8'd150, 1'b0);

    // Held start: back-to-back passes, one IDLE cycle apart
    push_pass(8'd60, 8'd90, 8'd180, 8'd230);
    push_pass(8'd60, 8'd90, 8'd180, 8'd230);
    push_pass(8'd60, 8'd90, 8'd180, 8'd230);
    lx = 8'd60; ly = 8'd90; rx = 8'd180; ry = 8'd230;
    start = 1'b1;
    dones = 0;
    d1 = -1;
    p2 = -1;
    for (int c = 0; c < 1200 && dones < 3; c++) begin
      tick();
      if (c == 699) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) d1 = c;
      end
      if (d1 >= 0 && p2 < 0 && c > d1 && plot === 1'b1) p2 = c;
    end
    start = 1'b0;
    check("held_done_count", 32'(dones), 32'd3);
    check("held_first_done", 32'(d1), 32'd321);
    check("held_gap", 32'(p2 - d1), 32'd2);
    repeat (5) tick();
    check("held_drained", 32'(exp_q.size()), 32'd0);
    check("held_idle", {30'b0, busy, plot}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
